// File: rtl/alu_pkg.sv
// Shared opcode encodings, ALU one-hot decode and issue-stage FSM states.
package alu_pkg;

  localparam int unsigned OPCODE_W = 4;
  localparam int unsigned NUM_OPS  = 12;
  localparam int unsigned ALU_OP_W = 12;

  localparam int unsigned OP_ADD  = 0;
  localparam int unsigned OP_SUB  = 1;
  localparam int unsigned OP_AND  = 2;
  localparam int unsigned OP_LOR  = 3;
  localparam int unsigned OP_SLL  = 4;
  localparam int unsigned OP_SRA  = 5;
  localparam int unsigned OP_ROR  = 6;
  localparam int unsigned OP_SLT  = 7;
  localparam int unsigned OP_SLTU = 8;
  localparam int unsigned OP_ADDC = 9;
  localparam int unsigned OP_XOR  = 10;
  localparam int unsigned OP_IOTA = 11;

  typedef logic [OPCODE_W-1:0] opcode_t;

  typedef enum logic {
    IDLE,
    EXEC
  } state_e;

  // Illegal opcodes decode to no ALU operation at all.
  function automatic logic [ALU_OP_W-1:0] op_onehot(input int unsigned opcode);
    logic [ALU_OP_W-1:0] oh;
    oh = '0;
    if (opcode < NUM_OPS) oh = ALU_OP_W'(1) << opcode;
    return oh;
  endfunction

endpackage

// File: rtl/alu_result_fifo.sv
// Synchronous result FIFO; head data reads as zero while empty.
module alu_result_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 9
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         head_o,
  output logic                     empty_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] DEPTH_C = DEPTH[PW:0];

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wptr_q;
  logic [PW-1:0]    rptr_q;
  logic [PW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == DEPTH_C);
  assign count_o = count_q;
  assign head_o  = empty_o ? '0 : mem_q[rptr_q];

  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= push_data_i;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ALU command front-end: issues one op per two cycles and queues results.
// Define ALU_FLAGS_EN to store {negative, zero} flags with each result.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned OPW   = OPCODE_W
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [OPW-1:0]      in_opcode,
  input  logic [7:0]          in_src1,
  input  logic [7:0]          in_src2,
  output logic [7:0]          alu_src1,
  output logic [7:0]          alu_src2,
  output logic [ALU_OP_W-1:0] alu_op,
  input  logic [7:0]          alu_result,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [7:0]          out_result,
  output logic                out_err
`ifdef ALU_FLAGS_EN
  ,
  output logic [1:0]          out_flags
`endif
);

`ifdef ALU_FLAGS_EN
  localparam int unsigned ENTRY_W = 11;
`else
  localparam int unsigned ENTRY_W = 9;
`endif
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  state_e              state_q;
  logic [7:0]          src1_q;
  logic [7:0]          src2_q;
  logic [ALU_OP_W-1:0] op_q;
  logic                err_q;

  logic [ALU_OP_W-1:0] in_onehot;
  logic                accept;
  logic                fifo_empty;
  logic                fifo_full;
  logic [CW-1:0]       fifo_count;
  logic [ENTRY_W-1:0]  push_data;
  logic [ENTRY_W-1:0]  fifo_head;
  logic [7:0]          push_res;

  assign in_onehot = op_onehot(32'(in_opcode));
  // Held low while reset is asserted so nothing is offered during reset.
  assign in_ready  = resetn && (state_q == IDLE) && (32'(fifo_count) < DEPTH);
  assign accept    = in_valid & in_ready;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      src1_q  <= '0;
      src2_q  <= '0;
      op_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q <= EXEC;
            src1_q  <= in_src1;
            src2_q  <= in_src2;
            op_q    <= in_onehot;
            err_q   <= ~|in_onehot;
          end
        end
        EXEC: begin
          state_q <= IDLE;
          op_q    <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign alu_src1 = src1_q;
  assign alu_src2 = src2_q;
  assign alu_op   = op_q;

  assign push_res = err_q ? 8'h00 : alu_result;

`ifdef ALU_FLAGS_EN
  logic [1:0] push_flags;
  assign push_flags = err_q ? 2'b01 : {push_res[7], push_res == 8'h00};
  assign push_data  = {push_flags, err_q, push_res};
  assign out_flags  = fifo_head[10:9];
`else
  assign push_data  = {err_q, push_res};
`endif

  alu_result_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk         (clk),
    .resetn      (resetn),
    .push_i      ((state_q == EXEC) && !fifo_full),
    .push_data_i (push_data),
    .pop_i       (out_ready),
    .head_o      (fifo_head),
    .empty_o     (fifo_empty),
    .full_o      (fifo_full),
    .count_o     (fifo_count)
  );

  assign out_valid  = ~fifo_empty;
  assign out_result = fifo_head[7:0];
  assign out_err    = fifo_head[8];

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage with a behavioural 12-op ALU on the alu_* ports.
`timescale 1ns/1ps
module tb_alu_issue_stage;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_opcode = '0;
  logic [7:0]  in_src1 = '0;
  logic [7:0]  in_src2 = '0;
  logic [7:0]  alu_src1;
  logic [7:0]  alu_src2;
  logic [11:0] alu_op;
  logic [7:0]  alu_result;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_result;
  logic        out_err;
`ifdef ALU_FLAGS_EN
  logic [1:0]  out_flags;
`endif

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [7:0] res;
    logic       err;
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] r;
    logic       e;
  } vec_t;

  vec_t vecs [14] = '{
    '{4'd1,  8'h50, 8'h20, 8'h30, 1'b0},
    '{4'd2,  8'hF0, 8'h3C, 8'h30, 1'b0},
    '{4'd3,  8'hF0, 8'h0F, 8'hFF, 1'b0},
    '{4'd4,  8'h01, 8'h03, 8'h08, 1'b0},
    '{4'd5,  8'h80, 8'h02, 8'hE0, 1'b0},
    '{4'd6,  8'h81, 8'h01, 8'hC0, 1'b0},
    '{4'd7,  8'hFF, 8'h01, 8'h01, 1'b0},
    '{4'd8,  8'hFF, 8'h01, 8'h00, 1'b0},
    '{4'd9,  8'hFF, 8'h01, 8'h80, 1'b0},
    '{4'd10, 8'hF0, 8'h3C, 8'hCC, 1'b0},
    '{4'd11, 8'h41, 8'h00, 8'h42, 1'b0},
    '{4'd1,  8'h05, 8'h05, 8'h00, 1'b0},
    '{4'd1,  8'h00, 8'h01, 8'hFF, 1'b0},
    '{4'hF,  8'h12, 8'h34, 8'h00, 1'b1}
  };

  always #5 clk = ~clk;

  alu_issue_stage #(
    .DEPTH (DEPTH),
    .OPW   (4)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_opcode  (in_opcode),
    .in_src1    (in_src1),
    .in_src2    (in_src2),
    .alu_src1   (alu_src1),
    .alu_src2   (alu_src2),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_err    (out_err)
`ifdef ALU_FLAGS_EN
    ,
    .out_flags  (out_flags)
`endif
  );

  logic [8:0] addc_sum;
  always_comb begin
    addc_sum = {1'b0, alu_src1} + {1'b0, alu_src2};
    case (alu_op)
      12'h001: alu_result = alu_src1 + alu_src2;
      12'h002: alu_result = alu_src1 - alu_src2;
      12'h004: alu_result = alu_src1 & alu_src2;
      12'h008: alu_result = alu_src1 | alu_src2;
      12'h010: alu_result = alu_src1 << alu_src2[2:0];
      12'h020: alu_result = $signed(alu_src1) >>> alu_src2[2:0];
      12'h040: alu_result = (alu_src1 >> alu_src2[2:0]) | (alu_src1 << (4'd8 - {1'b0, alu_src2[2:0]}));
      12'h080: alu_result = {7'b0, $signed(alu_src1) < $signed(alu_src2)};
      12'h100: alu_result = {7'b0, alu_src1 < alu_src2};
      12'h200: alu_result = addc_sum[8:1];
      12'h400: alu_result = alu_src1 ^ alu_src2;
      12'h800: alu_result = alu_src1 + 8'd1;
      default: alu_result = 8'h00;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every handshake seen before a rising edge is one pop.
  always @(negedge clk) begin
    exp_t e;
    if (resetn && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_pop: got result %0h err %0b, expected no entry", out_result, out_err);
      end else begin
        e = exp_q.pop_front();
        chk("pop_result", 32'(out_result), 32'(e.res));
        chk("pop_err", 32'(out_err), 32'(e.err));
`ifdef ALU_FLAGS_EN
        chk("pop_flags", 32'(out_flags), e.err ? 32'h1 : 32'({e.res[7], e.res == 8'h00}));
`endif
      end
    end
  end

  task automatic issue(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] r, input logic e, input bit keep);
    int unsigned n;
    exp_t x;
    n = 0;
    in_valid  = 1'b1;
    in_opcode = op;
    in_src1   = a;
    in_src2   = b;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      tests++;
      fails++;
      $display("FAIL issue_timeout: in_ready stayed 0, expected 1 within 100 cycles");
    end else if (keep) begin
      x.res = r;
      x.err = e;
      exp_q.push_back(x);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int unsigned n;
    n = 0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_left", 32'(exp_q.size()), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("drain_out_valid", 32'(out_valid), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned acc;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_alu_op", 32'(alu_op), 32'd0);
    chk("rst_alu_src1", 32'(alu_src1), 32'd0);
    chk("rst_alu_src2", 32'(alu_src2), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_result", 32'(out_result), 32'd0);
    chk("rst_out_err", 32'(out_err), 32'd0);
`ifdef ALU_FLAGS_EN
    chk("rst_out_flags", 32'(out_flags), 32'd0);
`endif
    resetn = 1'b1;
    @(posedge clk);
    #1;
    chk("idle_in_ready", 32'(in_ready), 32'd1);

    out_ready = 1'b1;
    issue(4'd0, 8'h12, 8'h34, 8'h46, 1'b0, 1'b1);
    chk("e0_alu_op", 32'(alu_op), 32'h001);
    chk("e0_alu_src1", 32'(alu_src1), 32'h12);
    chk("e0_alu_src2", 32'(alu_src2), 32'h34);
    chk("e0_in_ready", 32'(in_ready), 32'd0);
    chk("e0_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    chk("e1_alu_op", 32'(alu_op), 32'h000);
    chk("e1_hold_src1", 32'(alu_src1), 32'h12);
    chk("e1_out_valid", 32'(out_valid), 32'd1);

    foreach (vecs[i]) issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].r, vecs[i].e, 1'b1);

    issue(4'hD, 8'hAA, 8'h55, 8'h00, 1'b1, 1'b1);
    chk("illegal_alu_op", 32'(alu_op), 32'h000);
    drain();

    out_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      issue(4'd0, 8'(16 * i), 8'h01, 8'(16 * i + 1), 1'b0, 1'b1);
    @(posedge clk);
    #1;
    in_valid  = 1'b1;
    in_opcode = 4'd10;
    in_src1   = 8'hA5;
    in_src2   = 8'h0F;
    acc = 0;
    repeat (5) begin
      @(negedge clk);
      if (in_ready) acc++;
    end
    chk("full_no_accept", 32'(acc), 32'd0);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("ready_after_pop", 32'(in_ready), 32'd1);
    issue(4'd10, 8'hA5, 8'h0F, 8'hAA, 1'b0, 1'b1);
    drain();

    out_ready = 1'b0;
    issue(4'd0, 8'h01, 8'h02, 8'h03, 1'b0, 1'b1);
    issue(4'd1, 8'h09, 8'h04, 8'h05, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    issue(4'd2, 8'h0F, 8'h3C, 8'h0C, 1'b0, 1'b1);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("pp_out_valid", 32'(out_valid), 32'd1);
    chk("pp_in_ready", 32'(in_ready), 32'd1);
    chk("pp_head", 32'(out_result), 32'h05);
    repeat (2) @(posedge clk);
    #1;
    chk("stall_head_stable", 32'(out_result), 32'h05);
    drain();

    out_ready = 1'b0;
    issue(4'd3, 8'h11, 8'h22, 8'h33, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    issue(4'd0, 8'h10, 8'h10, 8'h20, 1'b0, 1'b0);
    #2;
    resetn = 1'b0;
    #1;
    chk("midexec_alu_op", 32'(alu_op), 32'd0);
    chk("midexec_alu_src1", 32'(alu_src1), 32'd0);
    chk("midexec_out_valid", 32'(out_valid), 32'd0);
    chk("midexec_in_ready", 32'(in_ready), 32'd0);
    chk("midexec_out_result", 32'(out_result), 32'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    resetn = 1'b1;
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("post_reset_empty", 32'(out_valid), 32'd0);
    out_ready = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
